// File: rtl/opl3_pkg.sv
// Shared OPL3 definitions: clock-enable channel modes, enable indices and tick rates.
package opl3_pkg;

  typedef enum logic {
    CLK_EN_FRACTIONAL,
    CLK_EN_INTEGER
  } clk_en_mode_t;

  localparam int SAMPLE_CLK_EN_IDX = 0;
  localparam int TIMER1_CLK_EN_IDX = 1;
  localparam int TIMER2_CLK_EN_IDX = 2;

  localparam int TIMER1_TICK_FREQ = 12500;
  localparam int TIMER2_TICK_FREQ = 3125;

  localparam int CLK_EN_MAX_OUTPUTS = 8;

  // A zero divisor only happens for an illegal rate, which the channel rejects anyway.
  function automatic int clk_en_div_ceil(input int num, input int den);
    if (den <= 0) return 1;
    return (num + den - 1) / den;
  endfunction

  // Holds acc + step before the threshold subtraction without overflow.
  function automatic int clk_en_acc_width(input int clk_freq, input int out_freq);
    return $clog2(clk_freq + out_freq) + 1;
  endfunction

endpackage

// File: rtl/opl3_clk_en_chan.sv
// One clock-enable channel: fractional accumulator or integer divider, plus a
// wrapping count of the pulses it has issued.
module opl3_clk_en_chan
  import opl3_pkg::*;
#(
  parameter int           CLK_FREQ  = 12727000,
  parameter int           OUT_FREQ  = 49716,
  parameter clk_en_mode_t MODE      = CLK_EN_FRACTIONAL,
  parameter int           CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 restart,
  output logic                 clk_en,
  output logic [CNT_WIDTH-1:0] pulse_cnt
);

  if (OUT_FREQ < 1 || OUT_FREQ > CLK_FREQ / 2) begin : g_bad_freq
    $fatal(1, "opl3_clk_en_chan: OUT_FREQ %0d outside 1..CLK_FREQ/2", OUT_FREQ);
  end

  logic                 pulse_next;
  logic                 clk_en_reg;
  logic [CNT_WIDTH-1:0] pulse_cnt_reg;

  if (MODE == CLK_EN_FRACTIONAL) begin : g_frac
    localparam int ACC_W = clk_en_acc_width(CLK_FREQ, OUT_FREQ);
    localparam logic [ACC_W-1:0] STEP   = ACC_W'(OUT_FREQ);
    localparam logic [ACC_W-1:0] THRESH = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] acc_sum;

    // Restart wins over run and over a crossing that would happen this cycle.
    always_comb begin
      acc_sum    = acc_reg + STEP;
      acc_next   = acc_reg;
      pulse_next = 1'b0;
      if (restart) begin
        acc_next = '0;
      end else if (run) begin
        if (acc_sum >= THRESH) begin
          acc_next   = acc_sum - THRESH;
          pulse_next = 1'b1;
        end else begin
          acc_next = acc_sum;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) acc_reg <= '0;
      else       acc_reg <= acc_next;
    end
  end else begin : g_int
    localparam int DIV   = clk_en_div_ceil(CLK_FREQ, OUT_FREQ);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;

    always_comb begin
      div_cnt_next = div_cnt_reg;
      pulse_next   = 1'b0;
      if (restart) begin
        div_cnt_next = '0;
      end else if (run) begin
        if (div_cnt_reg == TERM) begin
          div_cnt_next = '0;
          pulse_next   = 1'b1;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) div_cnt_reg <= '0;
      else       div_cnt_reg <= div_cnt_next;
    end
  end

  // The count moves on the same edge the pulse rises; restart leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_en_reg    <= 1'b0;
      pulse_cnt_reg <= '0;
    end else begin
      clk_en_reg <= pulse_next;
      if (pulse_next) pulse_cnt_reg <= pulse_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign clk_en    = clk_en_reg;
  assign pulse_cnt = pulse_cnt_reg;

endmodule

// File: rtl/opl3_multi_clk_en_gen.sv
// Multi-channel clock-enable generator: sample-rate enable and timer ticks
// derived from the system clock, one independent channel per output.
module opl3_multi_clk_en_gen
  import opl3_pkg::*;
#(
  parameter int           CLK_FREQ                = 12727000,
  parameter int           NUM_OUTPUTS             = 3,
  parameter int           OUT_FREQ [NUM_OUTPUTS]  = '{49716, TIMER1_TICK_FREQ, TIMER2_TICK_FREQ},
  parameter clk_en_mode_t OUT_MODE [NUM_OUTPUTS]  = '{CLK_EN_FRACTIONAL, CLK_EN_FRACTIONAL,
                                                      CLK_EN_FRACTIONAL},
  parameter int           CNT_WIDTH               = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_OUTPUTS-1:0]           run,
  input  logic [NUM_OUTPUTS-1:0]           restart,
  output logic [NUM_OUTPUTS-1:0]           clk_en,
  output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] pulse_cnt
);

  if (NUM_OUTPUTS < 1 || NUM_OUTPUTS > CLK_EN_MAX_OUTPUTS) begin : g_bad_num
    $fatal(1, "opl3_multi_clk_en_gen: NUM_OUTPUTS %0d outside 1..%0d",
           NUM_OUTPUTS, CLK_EN_MAX_OUTPUTS);
  end

  for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_chan
    opl3_clk_en_chan #(
      .CLK_FREQ  (CLK_FREQ),
      .OUT_FREQ  (OUT_FREQ[gi]),
      .MODE      (OUT_MODE[gi]),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .run       (run[gi]),
      .restart   (restart[gi]),
      .clk_en    (clk_en[gi]),
      .pulse_cnt (pulse_cnt[gi*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_opl3_multi_clk_en_gen.sv
// Bench: a small 1000 Hz configuration checked cycle by cycle against a
// queued reference model, plus default-rate instances checked for pulse timing.
module tb_opl3_multi_clk_en_gen;
  import opl3_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CLK_FREQ=1000, three 300 Hz channels (frac, frac, integer), 4-bit counts
  logic        reset = 1'b1;
  logic [2:0]  run = '0;
  logic [2:0]  restart = '0;
  logic [2:0]  a_clk_en;
  logic [11:0] a_pulse_cnt;

  // Instances B (default, fractional) and C (default rates, integer mode)
  logic        reset_d = 1'b1;
  logic [2:0]  run_d = '0;
  logic [2:0]  restart_d = '0;
  logic [2:0]  b_clk_en, c_clk_en;
  logic [47:0] b_pulse_cnt, c_pulse_cnt;

  opl3_multi_clk_en_gen #(
    .CLK_FREQ    (1000),
    .NUM_OUTPUTS (3),
    .OUT_FREQ    ('{300, 300, 300}),
    .OUT_MODE    ('{CLK_EN_FRACTIONAL, CLK_EN_FRACTIONAL, CLK_EN_INTEGER}),
    .CNT_WIDTH   (4)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .restart   (restart),
    .clk_en    (a_clk_en),
    .pulse_cnt (a_pulse_cnt)
  );

  opl3_multi_clk_en_gen dut_b (
    .clk       (clk),
    .reset     (reset_d),
    .run       (run_d),
    .restart   (restart_d),
    .clk_en    (b_clk_en),
    .pulse_cnt (b_pulse_cnt)
  );

  opl3_multi_clk_en_gen #(
    .OUT_MODE ('{CLK_EN_INTEGER, CLK_EN_INTEGER, CLK_EN_INTEGER})
  ) dut_c (
    .clk       (clk),
    .reset     (reset_d),
    .run       (run_d),
    .restart   (restart_d),
    .clk_en    (c_clk_en),
    .pulse_cnt (c_pulse_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -100000;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model for instance A, evaluated on each rising edge.
  typedef struct {
    logic [2:0]  en;
    logic [11:0] cnt;
  } sb_t;
  sb_t sb_q[$];

  localparam int A_CLK = 1000;
  localparam int A_F   = 300;
  localparam int A_DIV = 4;
  int a_is_int [3] = '{0, 0, 1};
  int m_acc [3];
  int m_cnt [3];

  always @(posedge clk) begin
    sb_t e;
    int  acc;
    int  cnt;
    e.en  = '0;
    e.cnt = '0;
    for (int ch = 0; ch < 3; ch++) begin
      acc = m_acc[ch];
      cnt = m_cnt[ch];
      if (reset) begin
        acc = 0;
        cnt = 0;
      end else if (restart[ch]) begin
        acc = 0;
      end else if (run[ch]) begin
        if (a_is_int[ch] != 0) begin
          if (acc == A_DIV - 1) begin
            acc = 0;
            e.en[ch] = 1'b1;
          end else begin
            acc = acc + 1;
          end
        end else begin
          acc = acc + A_F;
          if (acc >= A_CLK) begin
            acc = acc - A_CLK;
            e.en[ch] = 1'b1;
          end
        end
        if (e.en[ch]) cnt = (cnt + 1) % 16;
      end
      m_acc[ch] <= acc;
      m_cnt[ch] <= cnt;
      e.cnt[ch*4 +: 4] = 4'(cnt);
    end
    sb_q.push_back(e);
  end

  // Pulse timestamps (edge index) per instance/channel.
  int a_t0[$], a_t1[$], a_t2[$];
  int b_t0[$], b_t1[$], b_t2[$];
  int c_t0[$], c_t1[$], c_t2[$];

  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_val("a_clk_en", a_clk_en, e.en);
      check_val("a_pulse_cnt", a_pulse_cnt, e.cnt);
    end
    if (a_clk_en[0]) a_t0.push_back(cyc);
    if (a_clk_en[1]) a_t1.push_back(cyc);
    if (a_clk_en[2]) a_t2.push_back(cyc);
    if (b_clk_en[0]) b_t0.push_back(cyc);
    if (b_clk_en[1]) b_t1.push_back(cyc);
    if (b_clk_en[2]) b_t2.push_back(cyc);
    if (c_clk_en[0]) c_t0.push_back(cyc);
    if (c_clk_en[1]) c_t1.push_back(cyc);
    if (c_clk_en[2]) c_t2.push_back(cyc);
  end

  int p1_exp [6] = '{5, 8, 11, 15, 18, 21};

  initial begin
    int rel;
    bit found;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_clk_en", a_clk_en, 0);
    check_val("reset_pulse_cnt", a_pulse_cnt, 0);
    check_val("reset_b_pulse_cnt", b_pulse_cnt, 0);
    $display("phase 0: reset state checked");

    // 1000 running cycles from reset release
    @(negedge clk); #1;
    reset = 1'b0;
    run   = 3'b111;
    rel   = cyc;
    a_t0.delete(); a_t1.delete(); a_t2.delete();
    repeat (1000) @(negedge clk);
    #1;
    run = 3'b000;
    for (int i = 0; i < 6; i++)
      check_val($sformatf("p1_pulse_cycle%0d", i), q_at(a_t0, i) - rel + 1, p1_exp[i]);
    check_val("p1_frac_count", a_t0.size(), 300);
    check_val("p1_frac_cnt_wrap", a_pulse_cnt[3:0], 300 % 16);
    check_val("p1_int_count", a_t2.size(), 250);
    check_val("p1_int_period", q_at(a_t2, 1) - q_at(a_t2, 0), 4);
    check_val("p1_int_cnt_wrap", a_pulse_cnt[11:8], 250 % 16);
    $display("phase 1: fractional/integer rate over 1000 cycles");

    // run[0] dropped for 50 cycles after 2 running cycles
    @(negedge clk); #1;
    a_t0.delete();
    run = 3'b111;
    rel = cyc;
    repeat (2) @(negedge clk);
    #1 run[0] = 1'b0;
    repeat (50) @(negedge clk);
    #1 run[0] = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check_val("p2_resume_pulse", q_at(a_t0, 0) - rel, 54);
    $display("phase 2: run hold and resume");

    // restart ch0/ch1, then restart ch0 exactly on its crossing cycle
    restart = 3'b011;
    @(negedge clk); #1;
    restart = 3'b000;
    rel = cyc;
    a_t0.delete(); a_t1.delete();
    repeat (3) @(negedge clk);
    #1 restart = 3'b001;
    @(negedge clk);
    #1 restart = 3'b000;
    repeat (8) @(negedge clk);
    #1;
    check_val("p3_after_restart", q_at(a_t0, 0) - rel, 8);
    check_val("p3_other_chan", q_at(a_t1, 0) - rel, 4);
    $display("phase 3: restart on threshold crossing");

    // asynchronous reset while a pulse is showing
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (a_clk_en[0]) found = 1'b1;
    end
    check_val("p4_pulse_seen", found, 1);
    #1 reset = 1'b1;
    #1;
    if (found) begin
      check_val("p4_async_clk_en", a_clk_en, 0);
      check_val("p4_async_pulse_cnt", a_pulse_cnt, 0);
    end
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    $display("phase 4: asynchronous reset mid-run");

    // default rates, fractional (B) and integer (C), 5000 running cycles
    #1;
    reset_d = 1'b0;
    run_d   = 3'b111;
    rel     = cyc;
    repeat (5000) @(negedge clk);
    #1;
    run_d = 3'b000;
    check_val("b0_first", q_at(b_t0, 0) - rel, 256);
    check_val("b0_count", b_t0.size(), 19);
    check_val("b0_pulse_cnt", b_pulse_cnt[15:0], 19);
    check_val("b1_first", q_at(b_t1, 0) - rel, 1019);
    check_val("b1_second", q_at(b_t1, 1) - rel, 2037);
    check_val("b1_count", b_t1.size(), 4);
    check_val("b2_first", q_at(b_t2, 0) - rel, 4073);
    check_val("c0_first", q_at(c_t0, 0) - rel, 256);
    check_val("c0_count", c_t0.size(), 19);
    check_val("c0_span", q_at(c_t0, 18) - q_at(c_t0, 0), 256 * 18);
    check_val("c1_first", q_at(c_t1, 0) - rel, 1019);
    check_val("c1_span", q_at(c_t1, 3) - q_at(c_t1, 0), 3 * 1019);
    check_val("c1_pulse_cnt", c_pulse_cnt[31:16], 4);
    check_val("c2_first", q_at(c_t2, 0) - rel, 4073);
    $display("phase 5: default-rate channels");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/opl3_multi_clk_en_gen.md
Name: opl3_multi_clk_en_gen

Overview:
Parametrised, multi-channel clock-enable generator for the OPL3 core. It derives the sample-rate enable and the 80 us / 320 us timer ticks from the single system clock.
Each channel produces one-cycle pulses at a programmable rate, in one of two modes:
- fractional (exact long-term average rate)
- integer-divide (fixed period, ceil of CLK_FREQ/OUT_FREQ)

It replaces hand-set divide counts such as CLK_DIV_COUNT and sits beside the register file and timers at the top level.

Parameters:
CLK_FREQ, 12727000, system clock frequency in Hz (integer).
NUM_OUTPUTS, 3, number of independent enable channels (1..8).
OUT_FREQ, '{49716, 12500, 3125}, per-channel target rate in Hz (sample, timer1 80 us, timer2 320 us).
OUT_MODE, '{CLK_EN_FRACTIONAL, CLK_EN_FRACTIONAL, CLK_EN_FRACTIONAL}, per-channel mode (clk_en_mode_t).
CNT_WIDTH, 16, width of each per-channel debug pulse counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  NUM_OUTPUTS  per-channel run enable; low = hold state, no pulses
restart  in  NUM_OUTPUTS  per-channel synchronous phase restart (one-cycle strobe)
clk_en  out  NUM_OUTPUTS  per-channel registered one-cycle enable pulse
pulse_cnt  out  NUM_OUTPUTS x CNT_WIDTH (packed)  per-channel count of pulses issued, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset: all accumulators/counters = 0, clk_en = 0, pulse_cnt = 0.
- Elaboration checks, each a fatal error on failure:
  - 1 <= OUT_FREQ[i] <= CLK_FREQ/2;
  - NUM_OUTPUTS in range.
- Accumulator width: W = $clog2(CLK_FREQ + max OUT_FREQ) + 1, unsigned.
- Fractional mode, per cycle with run[i]=1 and restart[i]=0:
  - s = acc + OUT_FREQ[i];
  - if s >= CLK_FREQ: acc <= s - CLK_FREQ and clk_en[i] <= 1;
  - else: acc <= s and clk_en[i] <= 0.
  - Exactly OUT_FREQ[i] pulses per CLK_FREQ running cycles; period jitter is at most 1 cycle.
- Integer mode:
  - DIV = ceil(CLK_FREQ/OUT_FREQ[i]), computed at elaboration.
  - Counter runs 0..DIV-1; the terminal value sets clk_en[i] <= 1 and wraps to 0. Otherwise clk_en[i] <= 0.
- Latency: the pulse is registered; it appears the cycle after the update that reached the threshold/terminal value.
- Pulse width: always exactly 1 cycle. Back-to-back pulses are impossible because OUT_FREQ <= CLK_FREQ/2.
- run[i]=0: acc/counter hold their value, clk_en[i] <= 0. Resuming continues the phase; nothing is lost or duplicated.
- restart[i]=1 (dominates run and any pending threshold crossing): acc/counter <= 0, clk_en[i] <= 0. The following cycles behave as if freshly reset.
- pulse_cnt[i] increments in the same cycle clk_en[i] is asserted and wraps from 2^CNT_WIDTH-1 to 0. It is not cleared by restart.
- Channels are fully independent; simultaneous restarts/pulses on different channels do not interact.
- Reset asserted mid-operation: immediate asynchronous clear of all state and outputs.

Decomposition:
- Add to opl3_pkg:
  - typedef enum logic {CLK_EN_FRACTIONAL, CLK_EN_INTEGER} clk_en_mode_t;
  - localparams SAMPLE_CLK_EN_IDX=0, TIMER1_CLK_EN_IDX=1, TIMER2_CLK_EN_IDX=2;
  - TIMER1_TICK_FREQ=12500, TIMER2_TICK_FREQ=3125.
- One sub-module, opl3_clk_en_chan:
  - parameters CLK_FREQ, OUT_FREQ, MODE, CNT_WIDTH;
  - ports clk, reset, run, restart, clk_en, pulse_cnt.
- Top level is a generate loop over NUM_OUTPUTS.

Test Plan:
1. CLK_FREQ=1000, OUT_FREQ=300, fractional, run=1 from reset release: pulses visible at cycles 5, 8, 11, 15, 18, 21 (periods 4,3,3 repeating); 300 pulses in 1000 cycles; pulse_cnt=300.
2. Default params, channel 0 fractional: first pulse after 256 running cycles (255*49716 < 12727000 <= 256*49716). Over 12727000 cycles exactly 49716 pulses. Same channel in integer mode: period exactly 256.
3. Channel 1 (12500 Hz): fractional first period 1019, average period 1018.16 (12500 pulses per 12727000 cycles). Integer mode: constant period 1019.
4. run dropped for 50 cycles mid-period in test 1's config: no pulses while low; after resume the next pulse arrives after the remaining cycles (total running cycles unchanged).
5. restart asserted in the exact cycle a threshold crossing would occur: no pulse; acc=0; next pulse 4 cycles later (test 1 config); pulse_cnt unchanged; other channels unaffected.
6. CNT_WIDTH=4, 17 pulses: pulse_cnt reads 1. Reset asserted mid-run: clk_en and pulse_cnt drop to 0 asynchronously, before the next clock edge.
